pc_unit: RTL and testbench

Parametrised program-counter unit for the 64-bit LEGv8-style pipeline, the successor to the combinational next-PC logic. It holds the fetch PC in a register and supports stall hold. It resolves CBZ/CBNZ/B outcomes returned from execute and issues a one-cycle flush plus redirect on misprediction. An optional direct-mapped branch target buffer (BTB) with 2-bit saturating counters makes taken predictions at fetch.

---
 rtl/pc_pkg.sv | 34 +++
 rtl/pc_btb.sv | 99 +++++++++
 rtl/pc_unit.sv | 116 +++++++++++
 tb/tb_pc_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - 2-bit branch predictor counter states
//   - BTB entry layout (tag/target stored at a fixed maximum width of 64 bits,
//     so ADDR_W must not exceed PC_W_MAX)
//   - saturating counter update helper
package pc_pkg;

    localparam int unsigned PC_W_MAX = 64;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [PC_W_MAX-1:0] tag;
        logic [PC_W_MAX-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

    // Move the counter one step toward the resolved direction, saturating at the ends.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != STRONG_T) nxt = ctr + 2'd1;
        end else begin
            if (ctr != STRONG_NT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer with 2-bit counters.
// Only instantiated when PC_BTB_EN is defined.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears every entry)
//   fetch_pc           PC being fetched; looked up combinationally
//   hit_taken_c        hit with counter in a taken state
//   hit_target_c       stored target of the looked-up entry
//   upd_valid          execute stage holds a valid instruction
//   upd_pc             PC of the execute-stage instruction (update index/tag)
//   upd_is_branch      conditional or unconditional branch
//   upd_taken          resolved direction
//   upd_target         resolved branch target
//   upd_mispredict     execute-stage mispredict (used to evict aliased non-branches)
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              hit_taken_c,
    output logic [ADDR_W-1:0] hit_target_c,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_SH = IDX_W + 2;

    btb_entry_t mem_q [ENTRIES];
    btb_entry_t mem_d [ENTRIES];

    logic [IDX_W-1:0]    rd_idx;
    logic [PC_W_MAX-1:0] rd_tag;
    btb_entry_t          rd_entry;
    logic                rd_hit;

    logic [IDX_W-1:0]    wr_idx;
    logic [PC_W_MAX-1:0] wr_tag;
    btb_entry_t          wr_old;
    btb_entry_t          wr_new;
    logic                wr_hit;
    logic                wr_en;

    // Fetch-side lookup; reads pre-edge contents even when the same index is being written.
    always_comb begin : lookup
        rd_idx       = fetch_pc[2 +: IDX_W];
        rd_tag       = PC_W_MAX'(fetch_pc >> TAG_SH);
        rd_entry     = mem_q[rd_idx];
        rd_hit       = rd_entry.valid && (rd_entry.tag == rd_tag);
        hit_taken_c  = rd_hit && rd_entry.ctr[1];   // WEAK_T or STRONG_T
        hit_target_c = ADDR_W'(rd_entry.target);
    end

    // Execute-side training.
    always_comb begin : update
        wr_idx = upd_pc[2 +: IDX_W];
        wr_tag = PC_W_MAX'(upd_pc >> TAG_SH);
        wr_old = mem_q[wr_idx];
        wr_hit = wr_old.valid && (wr_old.tag == wr_tag);
        wr_new = wr_old;
        wr_en  = 1'b0;
        if (upd_valid && upd_is_branch) begin
            if (wr_hit) begin
                wr_en      = 1'b1;
                wr_new.ctr = ctr_update(wr_old.ctr, upd_taken);
                if (upd_taken) wr_new.target = PC_W_MAX'(upd_target);
            end else if (upd_taken) begin
                wr_en         = 1'b1;
                wr_new.valid  = 1'b1;
                wr_new.tag    = wr_tag;
                wr_new.target = PC_W_MAX'(upd_target);
                wr_new.ctr    = WEAK_T;
            end
        end else if (upd_valid && upd_mispredict && wr_hit) begin
            // A non-branch matched an entry by aliasing; drop it.
            wr_en        = 1'b1;
            wr_new.valid = 1'b0;
        end

        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = wr_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with stall hold, branch resolution and
// mispredict redirect for the 64-bit LEGv8-style pipeline.
// Optional BTB prediction is compiled in with the PC_BTB_EN macro; without it
// prediction is static not-taken (PredTarget = PC + 4).
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   StallEn               hold the fetch PC (a redirect overrides it)
//   PC                    current fetch PC (registered)
//   PredTaken/PredTarget  fetch prediction for PC, carried down the pipe
//   Ex*                   resolved instruction from execute with its carried prediction
//   Flush                 combinational mispredict indication to squash upstream stages
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       BTB_ENTRIES = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              StallEn,
    output logic [ADDR_W-1:0] PC,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredTarget,
    input  logic              ExValid,
    input  logic [ADDR_W-1:0] ExPC,
    input  logic [ADDR_W-1:0] ExImm,
    input  logic              ExBranch,
    input  logic              ExUncond,
    input  logic              ExZorNZ,
    input  logic              ExALUZero,
    input  logic              ExPredTaken,
    input  logic [ADDR_W-1:0] ExPredTarget,
    output logic              Flush
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] seq_next;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] fall_thru;
    logic [ADDR_W-1:0] actual_next;
    logic              taken;
    logic              mispredict;

    // Direction is already implied by the carried target, so only the target is compared.
    logic unused_ex_pred_taken;
    assign unused_ex_pred_taken = ExPredTaken;

    // Resolve the execute-stage instruction and compare against its carried prediction.
    always_comb begin : resolve
        br_target   = ExPC + (ExImm << 2);
        fall_thru   = ExPC + ADDR_W'(4);
        taken       = ExUncond | (ExBranch & (ExZorNZ ? ExALUZero : ~ExALUZero));
        actual_next = taken ? br_target : fall_thru;
        mispredict  = ExValid & (ExPredTarget != actual_next);
    end

    assign Flush    = mispredict;
    assign seq_next = pc_q + ADDR_W'(4);

`ifdef PC_BTB_EN
    logic              btb_taken_c;
    logic [ADDR_W-1:0] btb_target_c;

    pc_btb #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk            (Clk),
        .rst            (Reset),
        .fetch_pc       (pc_q),
        .hit_taken_c    (btb_taken_c),
        .hit_target_c   (btb_target_c),
        .upd_valid      (ExValid),
        .upd_pc         (ExPC),
        .upd_is_branch  (ExBranch | ExUncond),
        .upd_taken      (taken),
        .upd_target     (br_target),
        .upd_mispredict (mispredict)
    );

    always_comb begin : predict
        PredTaken  = btb_taken_c;
        PredTarget = btb_taken_c ? btb_target_c : seq_next;
    end
`else
    localparam int unsigned unused_btb_entries = BTB_ENTRIES;

    always_comb begin : predict
        PredTaken  = 1'b0;
        PredTarget = seq_next;
    end
`endif

    // Redirect beats stall; otherwise follow the fetch prediction.
    always_comb begin : next_pc
        pc_d = pc_q;
        if (mispredict) begin
            pc_d = actual_next;
        end else if (!StallEn) begin
            pc_d = PredTarget;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed bench for pc_unit with a behavioural reference model
// checked every cycle, plus hand-computed literal checkpoints.
// Build with PC_BTB_EN defined to also exercise the branch target buffer.
module tb_pc_unit;

    localparam int unsigned AW     = 64;
    localparam logic [63:0] RST_PC = 64'h100;
    localparam int unsigned NENT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [63:0] pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic        ex_branch;
    logic        ex_uncond;
    logic        ex_zornz;
    logic        ex_zero;
    logic        ex_ptaken;
    logic [63:0] ex_ptarget;
    logic        flush;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        cmp_en = 1'b0;

    logic [63:0] m_pc;
    logic [63:0] m_next;
    logic        m_flush;

    always #5 clk = ~clk;

    pc_unit #(
        .ADDR_W      (AW),
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (NENT)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .StallEn      (stall),
        .PC           (pc),
        .PredTaken    (pred_taken),
        .PredTarget   (pred_target),
        .ExValid      (ex_valid),
        .ExPC         (ex_pc),
        .ExImm        (ex_imm),
        .ExBranch     (ex_branch),
        .ExUncond     (ex_uncond),
        .ExZorNZ      (ex_zornz),
        .ExALUZero    (ex_zero),
        .ExPredTaken  (ex_ptaken),
        .ExPredTarget (ex_ptarget),
        .Flush        (flush)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ex_taken();
        if (ex_uncond) return 1'b1;
        if (!ex_branch) return 1'b0;
        return ex_zornz ? ex_zero : !ex_zero;
    endfunction

    function automatic logic [63:0] ex_target();
        return ex_pc + ex_imm * 64'd4;
    endfunction

    function automatic logic [63:0] ex_actual();
        return ex_taken() ? ex_target() : ex_pc + 64'd4;
    endfunction

    function automatic logic exp_flush();
        return ex_valid && (ex_ptarget != ex_actual());
    endfunction

`ifdef PC_BTB_EN
    logic        b_valid [NENT];
    logic [63:0] b_tag   [NENT];
    logic [63:0] b_tgt   [NENT];
    int          b_ctr   [NENT];

    function automatic int b_idx(input logic [63:0] a);
        return int'((a / 64'd4) % 64'(NENT));
    endfunction

    function automatic logic [63:0] b_tagof(input logic [63:0] a);
        return a / (64'd4 * 64'(NENT));
    endfunction

    function automatic logic b_hit(input logic [63:0] a);
        return b_valid[b_idx(a)] && (b_tag[b_idx(a)] == b_tagof(a));
    endfunction

    function automatic logic m_pred_taken();
        return b_hit(m_pc) && (b_ctr[b_idx(m_pc)] >= 2);
    endfunction

    function automatic logic [63:0] m_pred_target();
        return m_pred_taken() ? b_tgt[b_idx(m_pc)] : m_pc + 64'd4;
    endfunction
`else
    function automatic logic m_pred_taken();
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_pred_target();
        return m_pc + 64'd4;
    endfunction
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = RST_PC;
`ifdef PC_BTB_EN
            for (int i = 0; i < NENT; i++) b_valid[i] = 1'b0;
`endif
        end else begin
            m_flush = exp_flush();
            if (m_flush)     m_next = ex_actual();
            else if (stall)  m_next = m_pc;
            else             m_next = m_pred_target();
`ifdef PC_BTB_EN
            if (ex_valid) begin
                if (ex_branch || ex_uncond) begin
                    if (b_hit(ex_pc)) begin
                        if (ex_taken()) begin
                            if (b_ctr[b_idx(ex_pc)] < 3) b_ctr[b_idx(ex_pc)]++;
                            b_tgt[b_idx(ex_pc)] = ex_target();
                        end else if (b_ctr[b_idx(ex_pc)] > 0) begin
                            b_ctr[b_idx(ex_pc)]--;
                        end
                    end else if (ex_taken()) begin
                        b_valid[b_idx(ex_pc)] = 1'b1;
                        b_tag[b_idx(ex_pc)]   = b_tagof(ex_pc);
                        b_tgt[b_idx(ex_pc)]   = ex_target();
                        b_ctr[b_idx(ex_pc)]   = 2;
                    end
                end else if (m_flush && b_hit(ex_pc)) begin
                    b_valid[b_idx(ex_pc)] = 1'b0;
                end
            end
`endif
            m_pc = m_next;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc",          pc,          m_pc);
            chk("model_pred_taken",  pred_taken,  m_pred_taken());
            chk("model_pred_target", pred_target, m_pred_target());
            chk("model_flush",       flush,       exp_flush());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid = 0; ex_pc = '0; ex_imm = '0; ex_branch = 0; ex_uncond = 0;
        ex_zornz = 0; ex_zero = 0; ex_ptaken = 0; ex_ptarget = '0;
    endtask

    task automatic ex_set(input logic v, input logic [63:0] epc, input logic [63:0] imm,
                          input logic br, input logic unc, input logic zn, input logic z,
                          input logic pt, input logic [63:0] ptgt);
        ex_valid = v; ex_pc = epc; ex_imm = imm; ex_branch = br; ex_uncond = unc;
        ex_zornz = zn; ex_zero = z; ex_ptaken = pt; ex_ptarget = ptgt;
    endtask

    // Steer fetch to addr with a mispredicted non-branch sitting at addr-4.
    task automatic redirect(input logic [63:0] addr);
        ex_set(1, addr - 64'd4, '0, 0, 0, 0, 0, 0, addr ^ 64'h8);
        step();
        ex_clear();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        ex_clear();
        step();
        step();
        chk("reset_pc",         pc,         64'h100);
        chk("reset_pred_taken", pred_taken, 64'h0);
        chk("reset_flush",      flush,      64'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        step(); chk("seq_104", pc, 64'h104);
        step(); chk("seq_108", pc, 64'h108);
        chk("seq_pred_target", pred_target, 64'h10C);

        stall = 1'b1;
        repeat (3) begin
            step(); chk("stall_hold", pc, 64'h108);
        end
        stall = 1'b0;
        step(); chk("stall_release", pc, 64'h10C);

        // CBZ taken backward, predicted not-taken
        ex_set(1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1, 1, 0, 64'h204);
        #1 chk("cbz_flush", flush, 64'h1);
        step(); chk("cbz_redirect", pc, 64'h1F0);

        // CBNZ not taken, correctly predicted
        ex_set(1, 64'h400, 64'h10, 1, 0, 0, 1, 0, 64'h404);
        #1 chk("cbnz_no_flush", flush, 64'h0);
        step(); chk("cbnz_seq", pc, 64'h1F4);

        // forced mispredict while stalled
        stall = 1'b1;
        ex_ptarget = 64'h123;
        #1 chk("stall_mis_flush", flush, 64'h1);
        step(); chk("stall_redirect", pc, 64'h404);
        stall = 1'b0;

        // invalid execute slot never flushes
        ex_valid = 1'b0;
        #1 chk("invalid_no_flush", flush, 64'h0);
        step(); chk("invalid_seq", pc, 64'h408);

        // non-branch with a wrong carried target
        ex_set(1, 64'h600, '0, 0, 0, 0, 0, 1, 64'h700);
        #1 chk("nonbr_flush", flush, 64'h1);
        step(); chk("nonbr_redirect", pc, 64'h604);

        // wrap: target and fall-through both wrap to 0
        ex_set(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 0, 1, 0, 0, 0, 64'h0);
        #1 chk("wrap_no_flush", flush, 64'h0);
        step(); chk("wrap_seq", pc, 64'h608);
        ex_ptarget = 64'h500;
        #1 chk("wrap_flush", flush, 64'h1);
        step(); chk("wrap_pc", pc, 64'h0);

        // backward B across zero
        ex_set(1, 64'h4, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 0, 64'h8);
        #1 chk("bwrap_flush", flush, 64'h1);
        step(); chk("bwrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        ex_clear();
        step(); chk("pc_wraps", pc, 64'h0);

`ifdef PC_BTB_EN
        redirect(64'h300);
        chk("btb_at_300",   pc,         64'h300);
        chk("btb_cold_miss", pred_taken, 64'h0);
        // first taken instance: flush and allocate
        ex_set(1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 0, 64'h304);
        #1 chk("btb_first_flush", flush, 64'h1);
        step(); chk("btb_first_pc", pc, 64'h2F0);
        ex_clear();
        repeat (4) step();
        chk("btb_refetch",    pc,          64'h300);
        chk("btb_pred_taken", pred_taken,  64'h1);
        chk("btb_pred_tgt",   pred_target, 64'h2F0);
        // second taken instance, predicted correctly
        ex_set(1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 1, 64'h2F0);
        #1 chk("btb_second_no_flush", flush, 64'h0);
        step(); chk("btb_second_pc", pc, 64'h2F0);
        // not taken: flush to fall-through, counter 3 -> 2
        ex_set(1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 1, 1, 64'h2F0);
        #1 chk("btb_nt_flush", flush, 64'h1);
        step(); chk("btb_nt_pc", pc, 64'h304);
        ex_clear();
        redirect(64'h300);
        chk("btb_still_taken", pred_taken, 64'h1);
        // not taken again: counter 2 -> 1, prediction turns off
        ex_set(1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 1, 1, 64'h2F0);
        step(); chk("btb_nt2_pc", pc, 64'h304);
        ex_clear();
        redirect(64'h300);
        chk("btb_weak_nt",     pred_taken,  64'h0);
        chk("btb_weak_nt_tgt", pred_target, 64'h304);
`endif

        // reset in the middle of a pending redirect
        ex_set(1, 64'h800, 64'h8, 0, 1, 0, 0, 0, 64'h804);
        #1 rst = 1'b1;
        #1 chk("reset_async", pc, 64'h100);
        step(); chk("reset_abort", pc, 64'h100);
        ex_clear();
        rst = 1'b0;
        step(); chk("post_reset_seq", pc, 64'h104);

`ifdef PC_BTB_EN
        redirect(64'h300);
        chk("btb_reset_miss_300", pred_taken, 64'h0);
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        chk("btb_reset_miss_wrap", pred_taken, 64'h0);
`endif

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
